mem_access_unit: RTL and testbench

MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

---
 rtl/mem_access_unit.sv | 151 +++++++++++++++
 tb/tb_mem_access_unit.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_unit.sv
// Load/store sequencer between the control unit and a doubleword-wide memory:
// aligns, sign/zero-extends loads and read-modify-writes partial stores.
module mem_access_unit (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic        DMemWR,
  input  logic [3:0]  InstrIType,
  input  logic [63:0] addr,
  input  logic [63:0] wdata,
  output logic        busy,
  output logic        done,
  output logic        misalign,
  output logic [63:0] rdata,
  output logic [63:0] mem_addr,
  output logic        mem_wr,
  output logic [63:0] mem_wdata,
  input  logic [63:0] mem_rdata,
  output logic [2:0]  state_dbg
);

  // Handshake: start is sampled only in IDLE (busy=0); each accepted start
  // produces exactly one done pulse, and start may be raised again the cycle after done.
  typedef enum logic [2:0] {IDLE, RD_REQ, RD_DATA, WR, DONE, ERR} state_t;

  state_t      state, state_nxt;
  logic        dec_valid, dec_load, dec_signed, bad_access;
  logic [1:0]  dec_size;
  logic        load_q, signed_q;
  logic [1:0]  size_q;
  logic [2:0]  off_q;
  logic [63:0] wdata_q, shifted, ext, wsh, merged;
  logic [7:0]  mask_base, lane_mask;

  // Size codes: 0 = byte, 1 = half, 2 = word, 3 = doubleword
  always_comb begin
    dec_valid  = 1'b1;
    dec_load   = 1'b1;
    dec_signed = 1'b0;
    dec_size   = 2'd0;
    case (InstrIType)
      4'b1010: dec_size = 2'd3;
      4'b0010: begin dec_size = 2'd2; dec_signed = 1'b1; end
      4'b0001: begin dec_size = 2'd1; dec_signed = 1'b1; end
      4'b0000: begin dec_size = 2'd0; dec_signed = 1'b1; end
      4'b0011: dec_size = 2'd0;
      4'b0100: dec_size = 2'd1;
      4'b0101: dec_size = 2'd2;
      4'b0110: begin dec_size = 2'd3; dec_load = 1'b0; end
      4'b0111: begin dec_size = 2'd2; dec_load = 1'b0; end
      4'b1000: begin dec_size = 2'd1; dec_load = 1'b0; end
      4'b1001: begin dec_size = 2'd0; dec_load = 1'b0; end
      default: dec_valid = 1'b0;
    endcase
  end

  always_comb begin
    bad_access = !dec_valid || (dec_load == DMemWR);
    case (dec_size)
      2'd1:    bad_access = bad_access || addr[0];
      2'd2:    bad_access = bad_access || (|addr[1:0]);
      2'd3:    bad_access = bad_access || (|addr[2:0]);
      default: bad_access = bad_access;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (start) begin
          if (bad_access)                        state_nxt = ERR;
          else if (!dec_load && dec_size == 2'd3) state_nxt = WR;
          else                                   state_nxt = RD_REQ;
        end
      end
      RD_REQ:  state_nxt = RD_DATA;
      RD_DATA: state_nxt = load_q ? DONE : WR;
      WR:      state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      ERR:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign busy      = (state != IDLE);
  assign done      = (state == DONE) || (state == ERR);
  assign misalign  = (state == ERR);
  assign mem_wr    = (state == WR);
  assign state_dbg = state;

  // Load path: bring the addressed lane down to bit 0, then extend
  always_comb begin
    shifted = mem_rdata >> {off_q, 3'b000};
    case (size_q)
      2'd0:    ext = signed_q ? {{56{shifted[7]}},  shifted[7:0]}  : {56'd0, shifted[7:0]};
      2'd1:    ext = signed_q ? {{48{shifted[15]}}, shifted[15:0]} : {48'd0, shifted[15:0]};
      2'd2:    ext = signed_q ? {{32{shifted[31]}}, shifted[31:0]} : {32'd0, shifted[31:0]};
      default: ext = shifted;
    endcase
  end

  // Store path: overlay the low bytes of wdata onto the lanes being written
  always_comb begin
    case (size_q)
      2'd0:    mask_base = 8'h01;
      2'd1:    mask_base = 8'h03;
      2'd2:    mask_base = 8'h0F;
      default: mask_base = 8'hFF;
    endcase
    lane_mask = mask_base << off_q;
    wsh       = wdata_q << {off_q, 3'b000};
    merged    = mem_rdata;
    for (int i = 0; i < 8; i++) begin
      if (lane_mask[i]) merged[8*i +: 8] = wsh[8*i +: 8];
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      load_q    <= 1'b0;
      signed_q  <= 1'b0;
      size_q    <= 2'd0;
      off_q     <= 3'd0;
      wdata_q   <= 64'd0;
      mem_addr  <= 64'd0;
      mem_wdata <= 64'd0;
      rdata     <= 64'd0;
    end else begin
      if (state == IDLE && start) begin
        load_q    <= dec_load;
        signed_q  <= dec_signed;
        size_q    <= dec_size;
        off_q     <= addr[2:0];
        wdata_q   <= wdata;
        mem_addr  <= {addr[63:3], 3'b000};
        mem_wdata <= wdata;
      end
      if (state == RD_DATA) begin
        if (load_q) rdata     <= ext;
        else        mem_wdata <= merged;
      end
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit: single-doubleword memory model, write
// scoreboard on mem_wr, cycle-accurate latency and data checks.
module tb_mem_access_unit;

  logic        clock, reset, start, DMemWR;
  logic [3:0]  InstrIType;
  logic [63:0] addr, wdata, rdata, mem_addr, mem_wdata, mem_rdata;
  logic        busy, done, misalign, mem_wr;
  logic [2:0]  state_dbg;

  logic [63:0]  mem_word_addr, mem_word;
  logic [127:0] exp_q[$];
  int           n_cmp, n_err;

  mem_access_unit dut (
    .clock(clock), .reset(reset), .start(start), .DMemWR(DMemWR),
    .InstrIType(InstrIType), .addr(addr), .wdata(wdata),
    .busy(busy), .done(done), .misalign(misalign), .rdata(rdata),
    .mem_addr(mem_addr), .mem_wr(mem_wr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .state_dbg(state_dbg)
  );

  // clock / reset block
  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // memory model: one populated doubleword, one-cycle read latency
  always @(posedge clock)
    mem_rdata <= (mem_addr == mem_word_addr) ? mem_word : 64'hDEAD_DEAD_DEAD_DEAD;

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // scoreboard: every mem_wr cycle must match the next expected {addr,data}
  always @(negedge clock) begin
    if (reset && mem_wr) begin
      if (exp_q.size() == 0) begin
        check_val("wr_unexpected_addr", mem_addr, 64'hFFFF_FFFF_FFFF_FFFF);
      end else begin
        logic [127:0] e;
        e = exp_q.pop_front();
        check_val("wr_addr", mem_addr, e[127:64]);
        check_val("wr_data", mem_wdata, e[63:0]);
      end
    end
  end

  // driver: starts in the cycle after the previous call returned, which is the
  // cycle after done, so every access is issued back-to-back
  task automatic run_acc(input logic wr, input logic [3:0] code, input logic [63:0] a,
                         input logic [63:0] wd, input int poke,
                         output logic [63:0] done_cyc, output logic [63:0] wr_cyc,
                         output logic [63:0] wr_cnt, output logic [63:0] mis);
    @(posedge clock); #1;
    start = 1'b1; DMemWR = wr; InstrIType = code; addr = a; wdata = wd;
    done_cyc = 64'd0; wr_cyc = 64'd0; wr_cnt = 64'd0; mis = 64'd0;
    for (int k = 1; k <= 12 && done_cyc == 64'd0; k++) begin
      @(posedge clock); #1;
      start = 1'b0;
      addr  = 64'hFFFF_FFFF_FFFF_FFFF;
      wdata = {$urandom, $urandom};
      if (mem_wr) begin wr_cnt = wr_cnt + 64'd1; wr_cyc = 64'(k); end
      if (done) begin done_cyc = 64'(k); mis = {63'd0, misalign}; end
      if (k == poke) begin
        start = 1'b1; DMemWR = 1'b1; InstrIType = 4'b0110;
        addr = 64'h7000; wdata = 64'h5555_5555_5555_5555;
      end
    end
  endtask

  task automatic set_mem(input logic [63:0] a, input logic [63:0] d);
    mem_word_addr = a;
    mem_word      = d;
  endtask

  logic [63:0] dc, wc, wn, mis, cnt;

  initial begin
    n_cmp = 0; n_err = 0;
    reset = 1'b0; start = 1'b0; DMemWR = 1'b0; InstrIType = 4'b0000;
    addr = 64'd0; wdata = 64'd0;
    set_mem(64'd0, 64'd0);
    repeat (3) @(posedge clock);
    #1;
    check_val("rst_busy", {63'd0, busy}, 64'd0);
    check_val("rst_done", {63'd0, done}, 64'd0);
    check_val("rst_misalign", {63'd0, misalign}, 64'd0);
    check_val("rst_mem_wr", {63'd0, mem_wr}, 64'd0);
    check_val("rst_rdata", rdata, 64'd0);
    check_val("rst_mem_addr", mem_addr, 64'd0);
    check_val("rst_mem_wdata", mem_wdata, 64'd0);
    @(negedge clock) reset = 1'b1;

    // loads
    set_mem(64'h1000, 64'h80FF_0000_0000_0000);
    run_acc(1'b0, 4'b0000, 64'h1007, 64'd0, 0, dc, wc, wn, mis);
    check_val("lb_done_cyc", dc, 64'd3);
    check_val("lb_rdata", rdata, 64'hFFFF_FFFF_FFFF_FF80);
    check_val("lb_no_wr", wn, 64'd0);
    check_val("lb_misalign", mis, 64'd0);
    run_acc(1'b0, 4'b0011, 64'h1007, 64'd0, 0, dc, wc, wn, mis);
    check_val("lbu_done_cyc", dc, 64'd3);
    check_val("lbu_rdata", rdata, 64'h0000_0000_0000_0080);
    run_acc(1'b0, 4'b0001, 64'h1006, 64'd0, 0, dc, wc, wn, mis);
    check_val("lh_rdata", rdata, 64'hFFFF_FFFF_FFFF_80FF);
    run_acc(1'b0, 4'b0100, 64'h1006, 64'd0, 0, dc, wc, wn, mis);
    check_val("lhu_rdata", rdata, 64'h0000_0000_0000_80FF);
    set_mem(64'h5000, 64'h8765_4321_0000_0000);
    run_acc(1'b0, 4'b0010, 64'h5004, 64'd0, 0, dc, wc, wn, mis);
    check_val("lw_rdata", rdata, 64'hFFFF_FFFF_8765_4321);
    run_acc(1'b0, 4'b0101, 64'h5004, 64'd0, 0, dc, wc, wn, mis);
    check_val("lwu_rdata", rdata, 64'h0000_0000_8765_4321);
    set_mem(64'h6000, 64'h0123_4567_89AB_CDEF);
    run_acc(1'b0, 4'b1010, 64'h6000, 64'd0, 0, dc, wc, wn, mis);
    check_val("ld_done_cyc", dc, 64'd3);
    check_val("ld_rdata", rdata, 64'h0123_4567_89AB_CDEF);

    // partial stores
    set_mem(64'h2000, 64'hAAAA_AAAA_AAAA_AAAA);
    exp_q.push_back({64'h2000, 64'hAAAA_AAAA_1234_AAAA});
    run_acc(1'b1, 4'b1000, 64'h2002, 64'h1234, 0, dc, wc, wn, mis);
    check_val("sh_wr_cyc", wc, 64'd3);
    check_val("sh_wr_cnt", wn, 64'd1);
    check_val("sh_done_cyc", dc, 64'd4);
    exp_q.push_back({64'h2000, 64'h1122_3344_AAAA_AAAA});
    run_acc(1'b1, 4'b0111, 64'h2004, 64'hCAFE_BABE_1122_3344, 0, dc, wc, wn, mis);
    check_val("sw_wr_cnt", wn, 64'd1);
    check_val("sw_done_cyc", dc, 64'd4);
    set_mem(64'h2000, 64'd0);
    exp_q.push_back({64'h2000, 64'h0000_7700_0000_0000});
    run_acc(1'b1, 4'b1001, 64'h2005, 64'h0000_0000_0000_FF77, 0, dc, wc, wn, mis);
    check_val("sb_wr_cyc", wc, 64'd3);
    check_val("sb_rdata_kept", rdata, 64'h0123_4567_89AB_CDEF);

    // full store
    exp_q.push_back({64'h3000, 64'hDEAD_BEEF_0000_0001});
    run_acc(1'b1, 4'b0110, 64'h3000, 64'hDEAD_BEEF_0000_0001, 0, dc, wc, wn, mis);
    check_val("sd_wr_cyc", wc, 64'd1);
    check_val("sd_wr_cnt", wn, 64'd1);
    check_val("sd_done_cyc", dc, 64'd2);

    // error paths: misaligned, kind mismatch, undefined code
    run_acc(1'b0, 4'b0010, 64'h4002, 64'd0, 0, dc, wc, wn, mis);
    check_val("lw_mis_done_cyc", dc, 64'd1);
    check_val("lw_mis_flag", mis, 64'd1);
    check_val("lw_mis_no_wr", wn, 64'd0);
    check_val("lw_mis_rdata_kept", rdata, 64'h0123_4567_89AB_CDEF);
    run_acc(1'b1, 4'b1000, 64'h2001, 64'h1234, 0, dc, wc, wn, mis);
    check_val("sh_mis_flag", mis, 64'd1);
    check_val("sh_mis_no_wr", wn, 64'd0);
    run_acc(1'b1, 4'b0110, 64'h3004, 64'h1, 0, dc, wc, wn, mis);
    check_val("sd_mis_flag", mis, 64'd1);
    check_val("sd_mis_no_wr", wn, 64'd0);
    run_acc(1'b0, 4'b1010, 64'h6004, 64'd0, 0, dc, wc, wn, mis);
    check_val("ld_mis_flag", mis, 64'd1);
    run_acc(1'b1, 4'b0000, 64'h1007, 64'd0, 0, dc, wc, wn, mis);
    check_val("kind_err_done_cyc", dc, 64'd1);
    check_val("kind_err_flag", mis, 64'd1);
    run_acc(1'b0, 4'b0111, 64'h2004, 64'd0, 0, dc, wc, wn, mis);
    check_val("kind_err2_flag", mis, 64'd1);
    run_acc(1'b0, 4'b1111, 64'h1000, 64'd0, 0, dc, wc, wn, mis);
    check_val("undef_err_flag", mis, 64'd1);
    check_val("undef_rdata_kept", rdata, 64'h0123_4567_89AB_CDEF);

    // start while busy is ignored; a following access is accepted right after done
    set_mem(64'h1000, 64'h80FF_0000_0000_0000);
    run_acc(1'b0, 4'b0000, 64'h1007, 64'd0, 1, dc, wc, wn, mis);
    check_val("busy_start_done_cyc", dc, 64'd3);
    check_val("busy_start_no_wr", wn, 64'd0);
    check_val("busy_start_rdata", rdata, 64'hFFFF_FFFF_FFFF_FF80);
    run_acc(1'b0, 4'b0011, 64'h1007, 64'd0, 0, dc, wc, wn, mis);
    check_val("b2b_done_cyc", dc, 64'd3);
    check_val("b2b_rdata", rdata, 64'h0000_0000_0000_0080);

    // reset asserted while sb sits in RD_DATA
    set_mem(64'h2000, 64'd0);
    @(posedge clock); #1;
    start = 1'b1; DMemWR = 1'b1; InstrIType = 4'b1001; addr = 64'h2005; wdata = 64'h77;
    @(posedge clock); #1;
    start = 1'b0;
    @(posedge clock); #1;
    reset = 1'b0;
    #1;
    check_val("mid_rst_busy", {63'd0, busy}, 64'd0);
    check_val("mid_rst_done", {63'd0, done}, 64'd0);
    check_val("mid_rst_misalign", {63'd0, misalign}, 64'd0);
    check_val("mid_rst_mem_wr", {63'd0, mem_wr}, 64'd0);
    check_val("mid_rst_rdata", rdata, 64'd0);
    check_val("mid_rst_mem_addr", mem_addr, 64'd0);
    check_val("mid_rst_mem_wdata", mem_wdata, 64'd0);
    @(negedge clock) reset = 1'b1;
    cnt = 64'd0;
    for (int k = 0; k < 6; k++) begin
      @(posedge clock); #1;
      if (mem_wr) cnt = cnt + 64'd1;
    end
    check_val("mid_rst_no_wr_after", cnt, 64'd0);
    set_mem(64'h6000, 64'h0123_4567_89AB_CDEF);
    run_acc(1'b0, 4'b1010, 64'h6000, 64'd0, 0, dc, wc, wn, mis);
    check_val("post_rst_done_cyc", dc, 64'd3);
    check_val("post_rst_rdata", rdata, 64'h0123_4567_89AB_CDEF);

    repeat (2) @(posedge clock);
    check_val("wr_missing", 64'(exp_q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
